tri_wave_src: RTL and testbench

- Upstream stimulus stage for the fir block.
- Generates a 20-sample-period triangle wave in the fir input word format: bit15 sign, bits14:10 exponent code, bits9:0 mantissa.
- Delivers samples over a valid/ready interface, with a programmable sample-rate divider.
- Replaces hand-written sample sequences in benches and provides the on-chip test source.

---
 rtl/tri_wave_pkg.sv | 26 ++
 rtl/tri_wave_src_if.sv | 37 +++
 rtl/tri_level_enc.sv | 34 +++
 rtl/tri_wave_src.sv | 128 ++++++++++++
 tb/tb_tri_wave_src.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tri_wave_pkg.sv
// -----------------------------------------------------------------------------
// tri_wave_pkg
// Shared constants for the triangle-wave stimulus source: magnitude codes for
// the fir input word (exp[14:10], mantissa[9:0]), sign bit position, period
// length, phase width and the DOWN/UP state encoding.
// -----------------------------------------------------------------------------
package tri_wave_pkg;

  localparam int SIGN_BIT = 15;
  localparam int PERIOD   = 20;
  localparam int PHASE_W  = 5;

  // 15-bit magnitude field {exponent code, mantissa} for |level| = 0..5
  localparam logic [14:0] LVL_MAG0 = {5'b00000, 10'b0000000000};
  localparam logic [14:0] LVL_MAG1 = {5'b00011, 10'b1001100110};
  localparam logic [14:0] LVL_MAG2 = {5'b00010, 10'b1001100110};
  localparam logic [14:0] LVL_MAG3 = {5'b00001, 10'b0011001100};
  localparam logic [14:0] LVL_MAG4 = {5'b00001, 10'b1001100110};
  localparam logic [14:0] LVL_MAG5 = {5'b10000, 10'b0000000000};

  typedef enum logic {
    DOWN = 1'b0,
    UP   = 1'b1
  } state_t;

endpackage

// File: rtl/tri_wave_src_if.sv
// -----------------------------------------------------------------------------
// tri_wave_src_if
// Sample stream between the triangle source and its consumer.
//   sample_out   : current sample word
//   sample_valid : sample_out holds an unconsumed sample
//   ready        : consumer accepts the sample this cycle
//   phase        : period index 0..19 of the sample in sample_out
//   period_done  : one-cycle pulse when a new period's phase-0 sample appears
// Modports: master (source side), slave (consumer side).
// -----------------------------------------------------------------------------
interface tri_wave_src_if
  import tri_wave_pkg::*;
();

  logic [15:0]        sample_out;
  logic               sample_valid;
  logic               ready;
  logic [PHASE_W-1:0] phase;
  logic               period_done;

  modport master (
    output sample_out,
    output sample_valid,
    output phase,
    output period_done,
    input  ready
  );

  modport slave (
    input  sample_out,
    input  sample_valid,
    input  phase,
    input  period_done,
    output ready
  );

endinterface

// File: rtl/tri_level_enc.sv
// -----------------------------------------------------------------------------
// tri_level_enc
// Combinational map from a signed level (-5..+5) to the 16-bit fir input word.
//   level : signed 4-bit level
//   word  : {sign, exponent code, mantissa}
// Negative levels only set the sign bit; level 0 is always +0.
// -----------------------------------------------------------------------------
module tri_level_enc
  import tri_wave_pkg::*;
(
  input  logic signed [3:0] level,
  output logic [15:0]       word
);

  logic [3:0]  mag;
  logic [14:0] mag_code;

  always_comb begin
    mag      = level[3] ? 4'(-level) : 4'(level);
    mag_code = LVL_MAG0;
    case (mag)
      4'd1:    mag_code = LVL_MAG1;
      4'd2:    mag_code = LVL_MAG2;
      4'd3:    mag_code = LVL_MAG3;
      4'd4:    mag_code = LVL_MAG4;
      4'd5:    mag_code = LVL_MAG5;
      default: mag_code = LVL_MAG0;
    endcase
    word           = {1'b0, mag_code};
    // a negative level is never zero, so no -0 can appear
    word[SIGN_BIT] = level[3];
  end

endmodule

// File: rtl/tri_wave_src.sv
// -----------------------------------------------------------------------------
// tri_wave_src
// 20-sample-period triangle wave source for the fir block, delivered over a
// valid/ready stream with a programmable sample-rate divider.
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-high
//   en   : run enable; low freezes divider and waveform
//   mode : (TRI_WAVE_SQUARE_EN only) 1 = square wave +5/-5, sampled per load
//   bus  : tri_wave_src_if.master (sample_out, sample_valid, ready, phase,
//          period_done)
// Build option: define TRI_WAVE_SQUARE_EN to add the mode input.
//
// state | meaning
// ------+------------------------------------------------------------
// DOWN  | each load emits level then decrements; at -5 turn to UP
// UP    | each load emits level then increments; at +5 turn to DOWN
// -----------------------------------------------------------------------------
module tri_wave_src
  import tri_wave_pkg::*;
#(
  parameter int DIV   = 1,
  parameter int DIV_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
`ifdef TRI_WAVE_SQUARE_EN
  input  logic mode,
`endif
  tri_wave_src_if.master bus
);

  logic [DIV_W-1:0]   div_cnt;
  state_t             state;
  logic signed [3:0]  level;
  logic               first;

  logic               slot_free;
  logic               advance;
  logic               load;
  logic [PHASE_W-1:0] next_phase;
  logic signed [3:0]  enc_level;
  logic [15:0]        enc_word;

  assign slot_free = !bus.sample_valid || bus.ready;
  assign advance   = en && slot_free;
  assign load      = advance && (div_cnt == DIV_W'(DIV - 1));

  // phase register shows the sample on the bus, so the very first load is
  // phase 0 rather than an increment of the reset value
  always_comb begin
    if (first || bus.phase == PHASE_W'(PERIOD - 1)) begin
      next_phase = '0;
    end else begin
      next_phase = bus.phase + 1'b1;
    end
  end

`ifdef TRI_WAVE_SQUARE_EN
  always_comb begin
    if (mode) begin
      enc_level = (next_phase < PHASE_W'(PERIOD / 2)) ? 4'sd5 : -4'sd5;
    end else begin
      enc_level = level;
    end
  end
`else
  assign enc_level = level;
`endif

  tri_level_enc u_enc (
    .level (enc_level),
    .word  (enc_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.sample_out   <= 16'h0000;
      bus.sample_valid <= 1'b0;
      bus.phase        <= '0;
      bus.period_done  <= 1'b0;
      div_cnt          <= '0;
      level            <= 4'sd5;
      state            <= DOWN;
      first            <= 1'b1;
    end else begin
      if (advance) begin
        div_cnt <= load ? '0 : div_cnt + 1'b1;
      end

      if (load) begin
        bus.sample_out   <= enc_word;
        bus.phase        <= next_phase;
        bus.sample_valid <= 1'b1;
        bus.period_done  <= !first && (next_phase == '0);
        first            <= 1'b0;
        case (state)
          DOWN: begin
            if (level == -4'sd5) begin
              state <= UP;
              level <= -4'sd4;
            end else begin
              level <= level - 4'sd1;
            end
          end
          UP: begin
            if (level == 4'sd5) begin
              state <= DOWN;
              level <= 4'sd4;
            end else begin
              level <= level + 4'sd1;
            end
          end
          default: begin
            state <= DOWN;
            level <= 4'sd5;
          end
        endcase
      end else begin
        bus.period_done <= 1'b0;
        if (bus.ready) begin
          bus.sample_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tri_wave_src.sv
// -----------------------------------------------------------------------------
// tb_tri_wave_src
// Bench for tri_wave_src: two instances (DIV=1 and DIV=4) checked every cycle
// against a load-counting reference model, plus a table of the first period
// and directed stall / enable-drop / reset-mid-stall sequences.
// With TRI_WAVE_SQUARE_EN defined the mode input is driven and checked too.
// -----------------------------------------------------------------------------
module tb_tri_wave_src;
  import tri_wave_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic en0, en1;
  logic mode_in;

  tri_wave_src_if b0 ();
  tri_wave_src_if b1 ();

  tri_wave_src #(.DIV(1), .DIV_W(16)) dut0 (
    .clk  (clk),
    .rst  (rst),
    .en   (en0),
`ifdef TRI_WAVE_SQUARE_EN
    .mode (mode_in),
`endif
    .bus  (b0.master)
  );

  tri_wave_src #(.DIV(4), .DIV_W(16)) dut1 (
    .clk  (clk),
    .rst  (rst),
    .en   (en1),
`ifdef TRI_WAVE_SQUARE_EN
    .mode (mode_in),
`endif
    .bus  (b1.master)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // ---------------- reference model: counts loads, derives everything ------
  int          m_div   [2] = '{1, 4};
  int          m_cnt   [2] = '{0, 0};
  int          m_loads [2] = '{0, 0};
  bit          m_valid [2] = '{1'b0, 1'b0};
  logic [15:0] m_word  [2] = '{16'h0, 16'h0};
  int          m_phase [2] = '{0, 0};
  bit          m_pd    [2] = '{1'b0, 1'b0};

  function automatic bit sq_mode();
`ifdef TRI_WAVE_SQUARE_EN
    return mode_in;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [15:0] ref_word(int p, bit sq);
    int lv, mag;
    logic [15:0] w;
    if (sq) lv = (p < 10) ? 5 : -5;
    else    lv = (p <= 10) ? 5 - p : p - 15;
    mag = (lv < 0) ? -lv : lv;
    case (mag)
      5:       w = 16'h4000;
      4:       w = 16'h0666;
      3:       w = 16'h04CC;
      2:       w = 16'h0A66;
      1:       w = 16'h0E66;
      default: w = 16'h0000;
    endcase
    if (lv < 0) w[15] = 1'b1;
    return w;
  endfunction

  task automatic model_step(input int d, input bit e, input bit r, input bit sq);
    bit slot, ld;
    int p;
    if (rst) begin
      m_cnt[d] = 0; m_loads[d] = 0; m_valid[d] = 0;
      m_word[d] = 16'h0; m_phase[d] = 0; m_pd[d] = 0;
      return;
    end
    slot = !m_valid[d] || r;
    ld   = e && slot && (m_cnt[d] == m_div[d] - 1);
    if (e && slot) m_cnt[d] = ld ? 0 : m_cnt[d] + 1;
    m_pd[d] = 1'b0;
    if (ld) begin
      p          = m_loads[d] % PERIOD;
      m_word[d]  = ref_word(p, sq);
      m_phase[d] = p;
      m_pd[d]    = (m_loads[d] > 0) && (p == 0);
      m_loads[d] = m_loads[d] + 1;
      m_valid[d] = 1'b1;
    end else if (r) begin
      m_valid[d] = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic cmp_model(input int d, input logic v, input logic [15:0] w,
                           input logic [4:0] ph, input logic pd);
    string tag;
    tag = (d == 0) ? "m0" : "m1";
    chk({tag, ".valid"}, {15'b0, v}, {15'b0, m_valid[d]});
    chk({tag, ".word"},  w, m_word[d]);
    chk({tag, ".phase"}, {11'b0, ph}, 16'(m_phase[d]));
    chk({tag, ".pd"},    {15'b0, pd}, {15'b0, m_pd[d]});
  endtask

  // one clock: model follows the edge, outputs compared 1 time unit later
  task automatic cycle();
    bit sq;
    @(posedge clk);
    sq = sq_mode();
    model_step(0, en0, b0.ready, sq);
    model_step(1, en1, b1.ready, sq);
    #1;
    cmp_model(0, b0.sample_valid, b0.sample_out, b0.phase, b0.period_done);
    cmp_model(1, b1.sample_valid, b1.sample_out, b1.phase, b1.period_done);
  endtask

  task automatic chk0(input string name, input logic v, input logic [15:0] w,
                      input logic [4:0] ph);
    chk({name, ".valid"}, {15'b0, b0.sample_valid}, {15'b0, v});
    chk({name, ".word"},  b0.sample_out, w);
    chk({name, ".phase"}, {11'b0, b0.phase}, {11'b0, ph});
  endtask

  typedef struct {
    logic [15:0] word;
    logic [4:0]  ph;
    logic        pd;
  } vec_t;

  vec_t tbl [21];
  logic [15:0] words [21] = '{16'h4000, 16'h0666, 16'h04CC, 16'h0A66, 16'h0E66,
                              16'h0000, 16'h8E66, 16'h8A66, 16'h84CC, 16'h8666,
                              16'hC000, 16'h8666, 16'h84CC, 16'h8A66, 16'h8E66,
                              16'h0000, 16'h0E66, 16'h0A66, 16'h04CC, 16'h0666,
                              16'h4000};

  initial begin
    for (int i = 0; i < 21; i++) begin
      tbl[i].word = words[i];
      tbl[i].ph   = 5'(i % 20);
      tbl[i].pd   = (i == 20);
    end

    rst = 1'b1; en0 = 1'b0; en1 = 1'b0; mode_in = 1'b0;
    b0.ready = 1'b1; b1.ready = 1'b1;
    cycle(); cycle();
    chk0("rst0", 1'b0, 16'h0000, 5'd0);
    chk("rst0.pd", {15'b0, b0.period_done}, 16'h0);
    chk("rst1.valid", {15'b0, b1.sample_valid}, 16'h0);
    chk("rst1.word", b1.sample_out, 16'h0);

    // first period, DIV=1 one sample per clock; DIV=4 every fourth clock
    rst = 1'b0; en0 = 1'b1; en1 = 1'b1;
    for (int k = 0; k < 21; k++) begin
      cycle();
      chk0("tbl", 1'b1, tbl[k].word, tbl[k].ph);
      chk("tbl.pd", {15'b0, b0.period_done}, {15'b0, tbl[k].pd});
      chk("div4.valid", {15'b0, b1.sample_valid}, {15'b0, ((k + 1) % 4) == 0});
      if (k == 3) chk("div4.first", b1.sample_out, 16'h4000);
    end

    // stall with phase 3 on the bus
    repeat (3) cycle();
    chk0("pre_stall", 1'b1, 16'h0A66, 5'd3);
    b0.ready = 1'b0;
    repeat (5) begin
      cycle();
      chk0("stall", 1'b1, 16'h0A66, 5'd3);
    end
    b0.ready = 1'b1;
    cycle();
    chk0("post_stall", 1'b1, 16'h0E66, 5'd4);

    // enable drop with phase 7 pending
    repeat (3) cycle();
    chk0("pre_en", 1'b1, 16'h8A66, 5'd7);
    en0 = 1'b0;
    cycle();
    chk0("en_consume", 1'b0, 16'h8A66, 5'd7);
    repeat (3) begin
      cycle();
      chk0("en_hold", 1'b0, 16'h8A66, 5'd7);
    end
    en0 = 1'b1;
    cycle();
    chk0("en_resume", 1'b1, 16'h84CC, 5'd8);

    // reset in the middle of a stall at phase 12
    repeat (4) cycle();
    chk0("pre_rst", 1'b1, 16'h84CC, 5'd12);
    b0.ready = 1'b0;
    repeat (2) cycle();
    rst = 1'b1;
    cycle();
    chk0("mid_rst", 1'b0, 16'h0000, 5'd0);
    rst = 1'b0; b0.ready = 1'b1;
    cycle();
    chk0("restart", 1'b1, 16'h4000, 5'd0);
    chk("restart.pd", {15'b0, b0.period_done}, 16'h0);
    for (int i = 1; i <= 20; i++) begin
      cycle();
      chk("restart.pdn", {15'b0, b0.period_done}, {15'b0, i == 20});
    end

`ifdef TRI_WAVE_SQUARE_EN
    rst = 1'b1; mode_in = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      chk0("square", 1'b1, ((i % 20) < 10) ? 16'h4000 : 16'hC000, 5'(i % 20));
      chk("square.pd", {15'b0, b0.period_done}, {15'b0, i == 20});
    end
`endif

    // randomized traffic checked against the model
    for (int i = 0; i < 4000; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      en0      = ($urandom_range(0, 9) != 0);
      en1      = ($urandom_range(0, 9) != 0);
      b0.ready = ($urandom_range(0, 2) != 0);
      b1.ready = ($urandom_range(0, 3) != 0);
`ifdef TRI_WAVE_SQUARE_EN
      if ($urandom_range(0, 49) == 0) mode_in = ~mode_in;
`endif
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
